// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU decoder and the iterative RV32M unit:
// ALU codes, ALUOp classes, M-extension funct7/funct3 values and FSM states.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SLTU = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1011;
    localparam logic [3:0] ALU_SRA  = 4'b1100;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;

    localparam logic [6:0] F7_MEXT = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic a_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
               (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f3);
        return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Multiply/divide datapath: magnitude operands, one shift-add or restoring
// step per strobe, and sign fix-up of the final result.
module mdu_iter_core
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            special,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] hi_q, lo_q, m_q, res_q;
    logic [2:0]      f3_q;
    logic            neg_q, negr_q;

    logic            a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] mag_a, mag_b, min_neg, special_res;
    logic [XLEN:0]   sum, shifted, diff;
    logic            ge;
    logic [XLEN-1:0] hi_n, lo_n, quo, rem, fin_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        a_neg    = a_is_signed(funct3) & op_a[XLEN-1];
        b_neg    = b_is_signed(funct3) & op_b[XLEN-1];
        mag_a    = a_neg ? -op_a : op_a;
        mag_b    = b_neg ? -op_b : op_b;
        min_neg  = {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (op_b == '0);
        ovf      = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (op_a == min_neg) && (op_b == '1);
        special  = funct3[2] && (div_zero || ovf);
        // funct3[1] selects remainder among the divide ops
        if (div_zero) special_res = funct3[1] ? op_a : '1;
        else          special_res = funct3[1] ? '0   : min_neg;
    end

    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        ge      = 1'b0;
        if (!f3_q[2]) begin
            // Product accumulates in {hi, lo}; multiplier bits drain out of lo
            sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end else begin
            shifted = {hi_q, lo_q[XLEN-1]};
            diff    = shifted - {1'b0, m_q};
            ge      = (shifted >= {1'b0, m_q});
            hi_n    = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_n    = {lo_q[XLEN-2:0], ge};
        end
        prod   = {hi_n, lo_n};
        prod_s = neg_q ? -prod : prod;
        quo    = neg_q ? -lo_n : lo_n;
        rem    = negr_q ? -hi_n : hi_n;
        if (!f3_q[2]) fin_res = (f3_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else          fin_res = f3_q[1] ? rem : quo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q   <= '0;
            lo_q   <= '0;
            m_q    <= '0;
            res_q  <= '0;
            f3_q   <= '0;
            neg_q  <= 1'b0;
            negr_q <= 1'b0;
        end else if (load) begin
            f3_q   <= funct3;
            neg_q  <= a_neg ^ b_neg;
            negr_q <= a_neg;
            hi_q   <= '0;
            lo_q   <= funct3[2] ? mag_a : mag_b;
            m_q    <= funct3[2] ? mag_b : mag_a;
            if (special) res_q <= special_res;
        end else if (step) begin
            hi_q <= hi_n;
            lo_q <= lo_n;
            if (finish) res_q <= fin_res;
        end
    end

    assign result = res_q;

endmodule

// File: rtl/alu_mdu_control.sv
// EX-stage ALU control decoder plus FSM sequencing the iterative RV32M unit
// with a busy/done stall handshake.
module alu_mdu_control
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_rtype,
    input  logic            start,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      alu_control,
    output logic            md_sel,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] md_result
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            load, step, finish, special;

    always_comb begin
        alu_control = ALU_AND;
        unique case (ALUOp)
            ALUOP_MEM: alu_control = ALU_ADD;
            ALUOP_BR: begin
                case (funct3)
                    3'b000, 3'b001: alu_control = ALU_SUB;
                    3'b100, 3'b101: alu_control = ALU_SLT;
                    3'b110, 3'b111: alu_control = ALU_SLTU;
                    default:        alu_control = ALU_AND;
                endcase
            end
            ALUOP_ARITH: begin
                case (funct3)
                    3'b000:  alu_control = (funct7[5] && is_rtype) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            default: alu_control = ALU_AND;
        endcase
        md_sel = (ALUOp == ALUOP_ARITH) && is_rtype && (funct7 == F7_MEXT);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && md_sel) begin
                    busy  = 1'b1;
                    load  = 1'b1;
                    cnt_d = '0;
                    if (special)        state_d = S_DONE;
                    else if (funct3[2]) state_d = S_DIV;
                    else                state_d = S_MUL;
                end
            end
            S_MUL, S_DIV: begin
                busy  = 1'b1;
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    finish  = 1'b1;
                    state_d = S_DONE;
                end
            end
            // The EX instruction present during DONE is the one completing
            default: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .finish  (finish),
        .funct3  (funct3),
        .op_a    (op_a),
        .op_b    (op_b),
        .special (special),
        .result  (md_result)
    );

endmodule

// File: tb/tb_alu_mdu_control.sv
// Directed bench for alu_mdu_control: decode vectors, multiply/divide results
// and latencies, special divides, and asynchronous reset mid-operation.
module tb_alu_mdu_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        is_rtype;
    logic        start;
    logic [31:0] op_a, op_b;
    logic [3:0]  alu_control;
    logic        md_sel, busy, done;
    logic [31:0] md_result;

    int checks = 0;
    int failures = 0;

    alu_mdu_control #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .ALUOp       (ALUOp),
        .funct3      (funct3),
        .funct7      (funct7),
        .is_rtype    (is_rtype),
        .start       (start),
        .op_a        (op_a),
        .op_b        (op_b),
        .alu_control (alu_control),
        .md_sel      (md_sel),
        .busy        (busy),
        .done        (done),
        .md_result   (md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [6:0] f7, input logic rt,
                       input logic [3:0] exp_alu, input logic exp_md);
        ALUOp = aop; funct3 = f3; funct7 = f7; is_rtype = rt;
        #1;
        chk({tag, "_alu"}, {28'd0, alu_control}, {28'd0, exp_alu});
        chk({tag, "_md"}, {31'd0, md_sel}, {31'd0, exp_md});
        if (!exp_md) chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_cyc, input logic hold);
        int done_cyc;
        int busy_cnt;
        logic [31:0] res;
        @(posedge clk); #1;
        ALUOp = 2'b10; is_rtype = 1'b1; funct7 = 7'b0000001; funct3 = f3;
        op_a = a; op_b = b; start = 1'b1;
        #1;
        chk({tag, "_md_sel"}, {31'd0, md_sel}, 32'd1);
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
        busy_cnt = 1;
        done_cyc = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                if (!hold) start = 1'b0;
                op_a = $urandom;
                op_b = $urandom;
            end
            if (done) begin
                done_cyc = k;
                chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
                break;
            end
            if (busy) busy_cnt++;
        end
        chk({tag, "_done_cycle"}, done_cyc, exp_cyc);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_cyc);
        chk({tag, "_result"}, md_result, exp_res);
        res = md_result;
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_result_hold"}, md_result, res);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; ALUOp = 2'b00; funct3 = 3'b000; funct7 = 7'd0;
        is_rtype = 1'b0; op_a = '0; op_b = '0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", md_result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        start = 1'b1;
        dec("sra",    2'b10, 3'b101, 7'b0100000, 1'b1, 4'b1100, 1'b0);
        dec("srl_i",  2'b10, 3'b101, 7'b0000001, 1'b0, 4'b1011, 1'b0);
        dec("mem",    2'b00, 3'b111, 7'b0000000, 1'b0, 4'b0010, 1'b0);
        dec("beq",    2'b01, 3'b000, 7'b0000000, 1'b0, 4'b0110, 1'b0);
        dec("blt",    2'b01, 3'b100, 7'b0000000, 1'b0, 4'b0111, 1'b0);
        dec("bgeu",   2'b01, 3'b111, 7'b0000000, 1'b0, 4'b1010, 1'b0);
        dec("br_udf", 2'b01, 3'b010, 7'b0000000, 1'b0, 4'b0000, 1'b0);
        dec("sub",    2'b10, 3'b000, 7'b0100000, 1'b1, 4'b0110, 1'b0);
        dec("addi",   2'b10, 3'b000, 7'b0100000, 1'b0, 4'b0010, 1'b0);
        dec("sll",    2'b10, 3'b001, 7'b0000000, 1'b1, 4'b1001, 1'b0);
        dec("sltu",   2'b10, 3'b011, 7'b0000000, 1'b1, 4'b1010, 1'b0);
        dec("xor",    2'b10, 3'b100, 7'b0000000, 1'b1, 4'b1000, 1'b0);
        dec("or",     2'b10, 3'b110, 7'b0000000, 1'b1, 4'b0001, 1'b0);
        dec("and",    2'b10, 3'b111, 7'b0000000, 1'b1, 4'b0000, 1'b0);
        dec("op11",   2'b11, 3'b000, 7'b0000000, 1'b1, 4'b0000, 1'b0);
        start = 1'b0;
        dec("mext",   2'b10, 3'b000, 7'b0000001, 1'b1, 4'b0010, 1'b1);
        @(posedge clk); #1;
        chk("no_done_non_m", {31'd0, done}, 32'd0);

        run_md("mul",    3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 33, 1'b0);
        run_md("mulh",   3'b001, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 33, 1'b0);
        run_md("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
        run_md("mulhsu", 3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_md("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        run_md("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_md("divu",   3'b101, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 33, 1'b0);
        run_md("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b0);
        run_md("divu_z", 3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1,  1'b0);
        run_md("rem_z",  3'b110, 32'd100,      32'd0,        32'd100,      1,  1'b0);
        run_md("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        run_md("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  1'b0);

        // Reset ten cycles into a divide
        @(posedge clk); #1;
        ALUOp = 2'b10; is_rtype = 1'b1; funct7 = 7'b0000001; funct3 = 3'b100;
        op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_done", {31'd0, done}, 32'd0);
        chk("async_rst_result", md_result, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_done", {31'd0, done}, 32'd0);

        run_md("mul_hold", 3'b000, 32'd12345, 32'd678, 32'd8369910, 33, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu_control.md
# alu_mdu_control

Successor to the EX-stage ALU control decoder. Generates the 4-bit ALU control code for the RV32I ALU and adds an iterative RV32M multiply/divide unit, parametrised in XLEN. Exposes a busy/done handshake so the pipeline stalls the EX stage while an M-extension instruction is in flight.

## Interface
- XLEN, 32: operand/result width; any value ≥ 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ALUOp  in  2  operation class from main control: 00 load/store/AUIPC, 01 branch, 10 R/I arithmetic.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- is_rtype  in  1  EX instruction is R-type; qualifies the M-extension decode.
- start  in  1  EX-stage instruction is valid this cycle.
- op_a, op_b  in  XLEN  rs1/rs2 operand values.
- alu_control  out  4  ALU code; combinational.
- md_sel  out  1  EX instruction is M-extension; combinational.
- busy  out  1  stall request to the hazard unit.
- done  out  1  result valid; one-cycle pulse.
- md_result  out  XLEN  M-extension result; held until the next accepted start.

## Operation
- Base decode, combinational:
  - ALUOp 00 → ADD 0010.
  - ALUOp 01 → beq/bne SUB 0110, blt/bge SLT 0111, bltu/bgeu SLTU 1010.
  - ALUOp 10 → ADD/SUB 0010/0110 (SUB only when funct7[5] && is_rtype), SLL 1001, SLT 0111, SLTU 1010, XOR 1000, SRL/SRA 1011/1100, OR 0001, AND 0000.
  - Undefined combinations → 0000; never X.
- md_sel = ALUOp==10 && is_rtype && funct7==0000001. When md_sel is 1, alu_control is still driven but the pipeline uses md_result.
- funct3 when md_sel is 1: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states IDLE, MUL, DIV, DONE.
  - IDLE + start + md_sel: latch operands, funct3 and the sign flags. Go to MUL or DIV.
  - Special divides skip the iteration, fix the result, and go straight to DONE:
    - divide by zero → quotient all-ones, remainder = op_a.
    - signed overflow (DIV/REM of 100…0 by −1) → quotient 100…0, remainder 0.
  - MUL: shift-add on operand magnitudes into a 2·XLEN accumulator, XLEN iterations. Then negate if the result is signed-negative (MULHSU: only op_a is signed). MUL returns the low half; the other multiplies return the high half.
  - DIV: restoring division on magnitudes, XLEN iterations. Quotient truncates toward zero; remainder takes the dividend's sign.
  - DONE → IDLE unconditionally. start is ignored in DONE: that cycle's EX instruction is the one completing.
- Iteration counter is $clog2(XLEN)+1 bits and clears on entry to MUL/DIV.
- Operand changes after acceptance are ignored.

## Timing
- Reset, asynchronous: state IDLE, busy 0, done 0, md_result 0, counter 0, accumulators 0. An in-flight operation is discarded.
- busy is combinational: 1 in IDLE when start && md_sel, and 1 throughout MUL/DIV; 0 in DONE.
- Accept at cycle 0:
  - Normal operation: busy 1 for cycles 0..XLEN, done=1 at cycle XLEN+1 (33 for XLEN=32).
  - Special divide: done=1 at cycle 1.
- md_result is registered and valid from the done cycle. It is stable until the next accepted start.
- Back-to-back M instructions: minimum spacing is one IDLE cycle after DONE.
- Non-M instructions never assert busy or done.

## Structure
- Shared package alu_pkg holds:
  - ALU control code constants.
  - ALUOp encodings.
  - funct7 value 0000001 (M-extension).
  - M funct3 codes.
  - FSM state encoding.
- Sub-module mdu_iter_core: operand/accumulator registers, shift-add/restore step, and sign fix-up. Driven by the FSM in alu_mdu_control through load, step and finish strobes.

## Test plan
- Base decode: ALUOp=10, funct3=101, funct7=0100000, is_rtype=1 → alu_control=1100, md_sel=0, busy=0. Repeat with is_rtype=0 and funct7=0000001 → alu_control=1011, md_sel=0.
- MUL a=0xFFFFFFFD, b=7 → busy cycles 0–32, done at cycle 33, md_result=0xFFFFFFEB.
- Multiply high-half variants:
  - MULH a=0xFFFFFFFD, b=7 → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Divide with signs: DIV −7/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Special divides, each with done at cycle 1:
  - DIVU 100/0 → 0xFFFFFFFF.
  - REM 100/0 → 100.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same → 0.
- Reset during DIV at cycle 10 → busy, done and md_result go to 0 immediately. Hold start through DONE to confirm no re-acceptance. A following MUL completes at full latency with the correct result.
